// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM encoding, op field layout,
// ALU control codes and flag bit positions.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int OP_CIN_BIT  = 0;
   localparam int OP_CTRL_LSB = 1;
   localparam int OP_CTRL_MSB = 3;

   localparam logic [2:0] CTRL_ADD   = 3'b000;
   localparam logic [2:0] CTRL_SHIFT = 3'b100;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_flag_reg.sv
// {N,Z,C,V} flag register for the ALU sequencer; only built when
// ALU_SEQ_FLAGS_EN is defined.
`ifdef ALU_SEQ_FLAGS_EN
module alu_flag_reg
   import alu_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       lo_cap,
   input  logic       load,
   input  logic       hi_pass,
   input  logic       neg,
   input  logic       zero,
   input  logic       carry,
   input  logic       ovf,
   output logic [3:0] flags
);

   logic       z_lo;
   logic [3:0] flags_nxt;

   // A double-width result is zero only when both halves were zero.
   always_comb begin
      flags_nxt         = '0;
      flags_nxt[FLAG_N] = neg;
      flags_nxt[FLAG_Z] = hi_pass ? (z_lo & zero) : zero;
      flags_nxt[FLAG_C] = carry;
      flags_nxt[FLAG_V] = ovf;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         z_lo  <= 1'b0;
         flags <= '0;
      end else begin
         if (lo_cap) z_lo  <= zero;
         if (load)   flags <= flags_nxt;
      end
   end

endmodule
`endif

// File: rtl/alu_sequencer.sv
// Runs one n-bit or 2n-bit operation through an external n-bit ALU, one or two
// passes per request. Flag storage is present only with ALU_SEQ_FLAGS_EN defined.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int n = 4,
   parameter int m = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [3:0]     op,
   input  logic           dbl,
   input  logic [2*n-1:0] a_in,
   input  logic [2*n-1:0] b_in,
   output logic [n-1:0]   alu_a,
   output logic [n-1:0]   alu_b,
   output logic [2:0]     alu_ctrl,
   output logic           alu_cin,
   input  logic [n-1:0]   alu_f,
   input  logic           alu_cout,
   input  logic           alu_v,
   input  logic           alu_z,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*n-1:0] result,
   output logic [3:0]     flags,
   output logic [1:0]     state_dbg
);

   // Handshake: a request transfers on a rising edge where in_valid && in_ready;
   // a result transfers on a rising edge where out_valid && out_ready. Both
   // valid and ready are level signals; result/flags hold while out_valid waits.

   localparam int unused_shift_w = m;

   state_t         state, state_nxt;
   logic [3:0]     op_q;
   logic           dbl_q;
   logic [2*n-1:0] a_q, b_q;
   logic           lo_cout;
   logic [2:0]     ctrl;
   logic           two_pass;

   assign ctrl      = op_q[OP_CTRL_MSB:OP_CTRL_LSB];
   // Shifts never chain across halves, so dbl is ignored for them.
   assign two_pass  = dbl_q && (ctrl != CTRL_SHIFT);
   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alu_ctrl  = '0;
      alu_cin   = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_LO;
         end
         ST_LO: begin
            alu_a     = a_q[n-1:0];
            alu_b     = b_q[n-1:0];
            alu_ctrl  = ctrl;
            alu_cin   = op_q[OP_CIN_BIT];
            state_nxt = two_pass ? ST_HI : ST_DONE;
         end
         ST_HI: begin
            alu_a     = a_q[2*n-1:n];
            alu_b     = b_q[2*n-1:n];
            alu_ctrl  = ctrl;
            alu_cin   = (ctrl == CTRL_ADD) ? lo_cout : op_q[OP_CIN_BIT];
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         op_q    <= '0;
         dbl_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         lo_cout <= 1'b0;
         result  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q  <= op;
                  dbl_q <= dbl;
                  a_q   <= a_in;
                  b_q   <= b_in;
               end
            end
            ST_LO: begin
               result[n-1:0]   <= alu_f;
               result[2*n-1:n] <= '0;
               lo_cout         <= alu_cout;
            end
            ST_HI: result[2*n-1:n] <= alu_f;
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_FLAGS_EN
   // N comes from alu_f[n-1] on the final pass, which is the MSB of the executed width.
   alu_flag_reg u_flag_reg (
      .clk     (clk),
      .rst     (rst),
      .lo_cap  (state == ST_LO),
      .load    (((state == ST_LO) && !two_pass) || (state == ST_HI)),
      .hi_pass (state == ST_HI),
      .neg     (alu_f[n-1]),
      .zero    (alu_z),
      .carry   (alu_cout),
      .ovf     (alu_v),
      .flags   (flags)
   );
`else
   logic unused_flag_inputs;
   assign unused_flag_inputs = alu_v ^ alu_z;
   assign flags = 4'b0000;
`endif

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter n, default 4, meaning ALU data width (one pass).
REQ-002 SHALL have parameter m, default 2, meaning shift width = log2(n).
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have rst  input  1  synchronous active-high reset.
REQ-005 SHALL have in_valid  input  1  request present; in_ready  output  1  sequencer idle, can accept.
REQ-006 SHALL have op  input  4  {ALU ctrl[2:0], cin}; dbl  input  1  double-width (2n) operation.
REQ-007 SHALL have a_in, b_in  input  2n  operands (low half only used when dbl=0).
REQ-008 SHALL have alu_a, alu_b  output  n  ALU operands; alu_ctrl  output  3; alu_cin  output  1.
REQ-009 SHALL have alu_f  input  n; alu_cout, alu_v, alu_z  input  1 each (combinational ALU return, same cycle).
REQ-010 SHALL have out_valid  output  1; out_ready  input  1; result  output  2n; flags  output  4 {N,Z,C,V}.

Function
REQ-011 SHALL implement FSM states IDLE, LO, HI, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-012 IDLE: on in_valid&in_ready, latch op, dbl, a_in, b_in; go to LO; otherwise stay.
REQ-013 LO: drive alu_a/alu_b = operand bits [n-1:0], alu_ctrl=op[3:1], alu_cin=op[0]; at edge capture alu_f into result[n-1:0], and capture alu_cout, alu_v, alu_z.
REQ-014 LO exit: go to HI if dbl=1 and ctrl is not 100 (shift); else DONE with result[2n-1:n]=0.
REQ-015 HI: drive operand bits [2n-1:n], alu_ctrl=op[3:1]; alu_cin = captured LO carry when ctrl=000, else op[0]; capture alu_f into result[2n-1:n]; go to DONE.
REQ-016 dbl=1 with ctrl=100 SHALL be executed as single-width (dbl ignored).
REQ-017 Flags on DONE entry: N = result MSB of executed width (bit n-1 or 2n-1); Z = alu_z (single) or z_lo & z_hi (double); C, V = alu_cout, alu_v of last pass.
REQ-018 DONE: hold result and flags stable until out_ready=1, then go to IDLE; no new request accepted in same cycle.
REQ-019 Latency in_valid accept → out_valid: 2 cycles single, 3 cycles double; throughput one request per latency+1 cycles minimum.
REQ-020 alu_* outputs SHALL be 0 in IDLE and DONE.

Reset
REQ-021 rst SHALL take priority over all inputs: state=IDLE, result=0, flags=0, out_valid=0, in_ready=1 on next cycle.
REQ-022 rst asserted in LO/HI/DONE SHALL abort the operation; no out_valid is produced for it.

Configuration
REQ-023 Macro ALU_SEQ_FLAGS_EN defined: flags register implemented per REQ-017, persisting until next DONE entry.
REQ-024 Macro ALU_SEQ_FLAGS_EN undefined: flags tied to 4'b0000, no flag storage; all other behaviour unchanged.

Structure
REQ-025 Shared package alu_seq_pkg SHALL hold FSM state encodings, op field positions, ctrl constant for ADD (000) and SHIFT (100), flag bit indices (N=3,Z=2,C=1,V=0).
REQ-026 Sub-module alu_flag_reg SHALL implement the flag register (compiled under ALU_SEQ_FLAGS_EN); n_bit_ALU is instantiated outside, in the parent.

Verification (n=4, ALU connected)
REQ-027 Single ADD op=0000, a=3, b=5 → out_valid 2 cycles after accept, result=8'h08, flags N=1 Z=0 C=0 V=1.
REQ-028 Double ADD op=0000, a=8'h0F, b=8'h01 → out_valid after 3 cycles, result=8'h10, flags N=0 Z=0 C=0 V=0.
REQ-029 Double SUB op=0001, a=8'h10, b=8'h01 → HI pass alu_cin=0 (LO borrow), result=8'h0F, C=1.
REQ-030 Double AND op=0100, a=8'hF0, b=8'h0F → result=8'h00, Z=1; HI pass alu_cin=0.
REQ-031 out_ready held 0 for 5 cycles in DONE → result/flags stable, in_ready=0, new in_valid ignored.
REQ-032 rst asserted during HI → next cycle IDLE, out_valid=0, result=0, flags=0, in_ready=1.
